// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM state encodings and the
// bit-counter width helper.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Counter must be able to hold the value WIDTH itself (shown in DONE).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_sequencer_reg.sv
// Parameterised shift register datapath: parallel load, shift with a fill bit
// entering the vacated end, and a synchronous clear used for reset and abort.
module shift_reg_w #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  // Next shifted value: left shift when MSB leaves first, right shift otherwise.
  always_comb begin
    w_shifted = r_q;
    if (MSB_FIRST) begin
      w_shifted = {r_q[WIDTH-2:0], fill};
    end else begin
      w_shifted = {fill, r_q[WIDTH-1:1]};
    end
  end

  // Register update; clear dominates load, load dominates shift.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= din;
    end else if (shift_en) begin
      r_q <= w_shifted;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Shift sequencer top: accepts a word over start/ready, then clocks exactly
// WIDTH bits out serially and pulses done. Holds FSM, bit counter and decode.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             fill,
  input  logic             abort,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             done
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_clr;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_q;

  assign w_cnt_inc  = r_bit_cnt + CNT_W'(1);
  // abort blocks a same-cycle start; reset is folded in through w_clr priority.
  assign w_accept   = (r_state == ST_IDLE) && start && !abort;
  // abort only clears the datapath while a transfer is in flight.
  assign w_clr      = reset || (abort && (r_state != ST_IDLE));
  assign w_shift_en = (r_state == ST_SHIFT);

  shift_reg_w #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk      (clk),
    .clr      (w_clr),
    .load     (w_accept),
    .shift_en (w_shift_en),
    .din      (din),
    .fill     (fill),
    .q        (w_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> SHIFT -> DONE -> IDLE, abort returns to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_cnt_inc == CNT_W'(WIDTH)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Bit counter: zeroed on accept/abort, counts every shift, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_bit_cnt <= '0;
        end
        ST_SHIFT: begin
          r_bit_cnt <= abort ? '0 : w_cnt_inc;
        end
        ST_DONE: begin
          if (abort) r_bit_cnt <= '0;
        end
        default: begin
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign ready      = (r_state == ST_IDLE);
  assign sout_valid = (r_state == ST_SHIFT);
  assign done       = (r_state == ST_DONE);
  assign sout       = MSB_FIRST ? w_q[WIDTH-1] : w_q[0];
  assign q          = w_q;
  assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: one LSB-first and one MSB-first instance.
// Stimulus pushes expected serial bits and done-time q values into queues;
// per-instance monitors pop and compare whenever the DUT presents them.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_start, a_fill, a_abort;
  logic [7:0] a_din;
  logic       a_ready, a_sout, a_sout_valid, a_done;
  logic [7:0] a_q;
  logic [3:0] a_bit_cnt;
  logic       b_start, b_fill, b_abort;
  logic [7:0] b_din;
  logic       b_ready, b_sout, b_sout_valid, b_done;
  logic [7:0] b_q;
  logic [3:0] b_bit_cnt;

  int checks = 0;
  int errors = 0;

  bit         a_bits[$];
  bit         b_bits[$];
  logic [7:0] a_qexp[$];
  logic [7:0] b_qexp[$];

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .din(a_din), .fill(a_fill),
    .abort(a_abort), .ready(a_ready), .sout(a_sout), .sout_valid(a_sout_valid),
    .q(a_q), .bit_cnt(a_bit_cnt), .done(a_done)
  );

  shift_sequencer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .din(b_din), .fill(b_fill),
    .abort(b_abort), .ready(b_ready), .sout(b_sout), .sout_valid(b_sout_valid),
    .q(b_q), .bit_cnt(b_bit_cnt), .done(b_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor for the LSB-first instance.
  always @(negedge clk) begin
    if (a_sout_valid === 1'b1) begin
      if (a_bits.size() == 0) chk("a_unexpected_sout", 1, 0);
      else chk("a_sout", a_sout, a_bits.pop_front());
    end
    if (a_done === 1'b1) begin
      if (a_qexp.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        chk("a_done_q", a_q, a_qexp.pop_front());
        chk("a_done_bitcnt", a_bit_cnt, 8);
        chk("a_done_ready", a_ready, 0);
      end
    end
  end

  // Monitor for the MSB-first instance.
  always @(negedge clk) begin
    if (b_sout_valid === 1'b1) begin
      if (b_bits.size() == 0) chk("b_unexpected_sout", 1, 0);
      else chk("b_sout", b_sout, b_bits.pop_front());
    end
    if (b_done === 1'b1) begin
      if (b_qexp.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        chk("b_done_q", b_q, b_qexp.pop_front());
        chk("b_done_bitcnt", b_bit_cnt, 8);
        chk("b_done_ready", b_ready, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) a_bits.push_back(w[i]);
  endtask

  logic [7:0] words5 [0:29];
  logic [7:0] b_steps [0:8];

  initial begin
    b_steps = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    for (int i = 0; i < 30; i++) words5[i] = 8'(8'h3B * (i + 1) + 8'h11);

    reset = 1'b1;
    a_start = 0; a_fill = 0; a_abort = 0; a_din = '0;
    b_start = 0; b_fill = 0; b_abort = 0; b_din = '0;
    cyc(3);
    reset = 1'b0;
    // Reset state
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_svalid", a_sout_valid, 0);
    chk("rst_a_q", a_q, 8'h00);
    chk("rst_a_cnt", a_bit_cnt, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_sout", a_sout, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_b_q", b_q, 8'h00);

    // Test 1: reset mid-SHIFT at bit_cnt=3, held 2 cycles
    a_din = 8'h3C; a_start = 1;
    push_a(8'h3C, 4);
    cyc(1);
    a_start = 0;
    cyc(3);
    chk("t1_cnt3", a_bit_cnt, 3);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    chk("t1_ready", a_ready, 1);
    chk("t1_svalid", a_sout_valid, 0);
    chk("t1_q", a_q, 8'h00);
    chk("t1_cnt", a_bit_cnt, 0);
    chk("t1_done", a_done, 0);
    cyc(2);

    // Test 2: LSB-first A5, fill 0
    a_din = 8'hA5; a_fill = 0; a_start = 1;
    push_a(8'hA5, 8);
    a_qexp.push_back(8'h00);
    cyc(1);
    a_start = 0; a_din = 8'hFF;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_svalid", a_sout_valid, 1);
      chk("t2_ready_low", a_ready, 0);
      cyc(1);
    end
    chk("t2_done_c9", a_done, 1);
    cyc(1);
    chk("t2_ready_c10", a_ready, 1);
    chk("t2_done_c10", a_done, 0);

    // Test 3: MSB-first 81, fill 1
    b_din = 8'h81; b_fill = 1; b_start = 1;
    b_bits.push_back(1);
    for (int i = 0; i < 6; i++) b_bits.push_back(0);
    b_bits.push_back(1);
    b_qexp.push_back(8'hFF);
    cyc(1);
    b_start = 0;
    cyc(8);
    chk("t3_done", b_done, 1);
    cyc(2);

    // Test 4: MSB-first 00, fill 1 -> q fills with ones one bit per cycle
    b_din = 8'h00; b_fill = 1; b_start = 1;
    for (int i = 0; i < 8; i++) b_bits.push_back(0);
    b_qexp.push_back(8'hFF);
    cyc(1);
    b_start = 0;
    for (int i = 0; i <= 8; i++) begin
      chk("t4_qstep", b_q, b_steps[i]);
      cyc(1);
    end
    cyc(1);

    // Test 5: start held high, din changing every cycle
    a_fill = 0;
    for (int c = 0; c < 30; c++) begin
      a_start = 1;
      a_din = words5[c];
      chk("t5_ready", a_ready, (c % 10 == 0) ? 1 : 0);
      if (c % 10 == 0) begin
        push_a(words5[c], 8);
        a_qexp.push_back(8'h00);
      end
      cyc(1);
    end
    a_start = 0;
    chk("t5_ready_end", a_ready, 1);
    cyc(2);

    // Test 6a: abort at bit_cnt=3
    a_din = 8'hF0; a_fill = 0; a_start = 1;
    push_a(8'hF0, 4);
    cyc(1);
    a_start = 0;
    cyc(3);
    chk("t6_cnt3", a_bit_cnt, 3);
    a_abort = 1;
    cyc(1);
    a_abort = 0;
    chk("t6_ready", a_ready, 1);
    chk("t6_q", a_q, 8'h00);
    chk("t6_cnt", a_bit_cnt, 0);
    chk("t6_svalid", a_sout_valid, 0);
    chk("t6_done", a_done, 0);
    cyc(10);

    // Test 6b: abort and start together in IDLE
    a_din = 8'hFF; a_start = 1; a_abort = 1;
    cyc(1);
    a_start = 0; a_abort = 0;
    chk("t6b_ready", a_ready, 1);
    chk("t6b_svalid", a_sout_valid, 0);
    chk("t6b_q", a_q, 8'h00);
    cyc(3);

    chk("a_bits_left", a_bits.size(), 0);
    chk("b_bits_left", b_bits.size(), 0);
    chk("a_done_left", a_qexp.size(), 0);
    chk("b_done_left", b_qexp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
